// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - single-clock FIFO for any DEPTH >= 2, with occupancy count and thresholds.
// Provides sticky overflow/underflow flags and a selectable registered or fall-through read port.
module param_sync_fifo #(
  parameter int DEPTH      = 6,
  parameter int DATA_WIDTH = 8,
  parameter int AF_TH      = 4,
  parameter int AE_TH      = 1,
  parameter int FWFT       = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          w_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          r_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          rvalid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          clr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_TH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags decode straight from the registered count, so they move on the same edge as count.
  assign full         = (cnt == FULL_CNT);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AF_CNT);
  assign almost_empty = (cnt <= AE_CNT);
  assign count        = cnt;

  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;

  // Storage is intentionally not reset; writes are still blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Explicit wrap at DEPTH-1 keeps non-power-of-two depths from aliasing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (w_en & full)  | (overflow  & ~clr_err);
      underflow <= (r_en & empty) | (underflow & ~clr_err);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem[rd_ptr];
      assign rvalid   = ~empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  rvalid_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dout_q   <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_acc;
          if (rd_acc) begin
            dout_q <= mem[rd_ptr];
          end
        end
      end

      assign data_out = dout_q;
      assign rvalid   = rvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - randomized and directed bench for param_sync_fifo against a queue model.
// Drives a registered-read and a fall-through instance with identical stimulus.
module tb_param_sync_fifo;

  localparam int DEPTH = 6;
  localparam int DW    = 8;
  localparam int AF_TH = 4;
  localparam int AE_TH = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] data_out, f_data_out;
  logic          rvalid, f_rvalid;
  logic          full, f_full, empty, f_empty;
  logic          almost_full, f_almost_full, almost_empty, f_almost_empty;
  logic [2:0]    count, f_count;
  logic          overflow, f_overflow, underflow, f_underflow;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  logic          m_rv  = 1'b0;
  logic [DW-1:0] m_dout = '0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_TH(AF_TH), .AE_TH(AE_TH), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(data_out), .rvalid(rvalid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  param_sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_TH(AF_TH), .AE_TH(AE_TH), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(f_data_out), .rvalid(f_rvalid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow), .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    logic [DW-1:0] head;
    n = q.size();
    head = (n > 0) ? q[0] : '0;
    check("count",        32'(count),        32'(n));
    check("full",         32'(full),         32'(n == DEPTH));
    check("empty",        32'(empty),        32'(n == 0));
    check("almost_full",  32'(almost_full),  32'(n >= AF_TH));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE_TH));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_unf));
    check("rvalid",       32'(rvalid),       32'(m_rv));
    check("data_out",     32'(data_out),     32'(m_dout));
    check("f_count",      32'(f_count),      32'(n));
    check("f_flags",      32'({f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow}),
          32'({n == DEPTH, n == 0, n >= AF_TH, n <= AE_TH, m_ovf, m_unf}));
    check("f_rvalid",     32'(f_rvalid),     32'(n > 0));
    check("f_data_out",   32'(f_data_out),   32'(head));
  endtask

  // One clock: apply inputs, advance the reference model by the accept rules, then compare.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic clr, input logic rst_assert);
    int  n;
    logic wa, ra;
    n = q.size();
    w_en = w; data_in = d; r_en = r; clr_err = clr; rst_n = ~rst_assert;
    @(posedge clk);
    #1;
    if (rst_assert) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_rv = 1'b0; m_dout = '0;
    end else begin
      wa = w && (n < DEPTH);
      ra = r && (n > 0);
      m_ovf = (w && n == DEPTH) || (m_ovf && !clr);
      m_unf = (r && n == 0)     || (m_unf && !clr);
      m_rv = ra;
      if (ra) begin
        m_dout = q[0];
        void'(q.pop_front());
      end
      if (wa) q.push_back(d);
    end
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    logic [DW-1:0] v;

    // Test 1: fill to full, then one write too many.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, DW'(8'h11 + i), 0, 0, 0);
    check("t1_count6", 32'(count), 32'd6);
    step(1, 8'h77, 0, 0, 0);
    check("t1_overflow", 32'(overflow), 32'd1);

    // Test 2: drain in order, extra read, then clear errors.
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0, 0);
      check("t2_order", 32'(data_out), 32'(8'h11 + i));
    end
    step(0, 0, 1, 0, 0);
    check("t2_underflow", 32'(underflow), 32'd1);
    step(0, 0, 0, 1, 0);

    // Test 3: hold occupancy at 3 across pointer wrap.
    for (int i = 0; i < 3; i++) step(1, DW'(8'h40 + i), 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, DW'(8'h50 + i), 1, 0, 0);
      check("t3_steady", 32'(count), 32'd3);
    end

    // Test 4: both requests while full, then while empty.
    for (int i = 0; i < 3; i++) step(1, DW'(8'h60 + i), 0, 0, 0);
    step(1, 8'h99, 1, 0, 0);
    check("t4_full_both", 32'(count), 32'd5);
    while (q.size() > 0) step(0, 0, 1, 0, 0);
    step(1, 8'h9A, 1, 1, 0);
    check("t4_empty_both", 32'(count), 32'd1);

    // Test 5: fall-through presentation of a single word.
    step(0, 0, 0, 0, 1);
    step(1, 8'hA5, 0, 0, 0);
    check("t5_fwft_data", 32'(f_data_out), 32'hA5);
    step(0, 0, 1, 0, 0);
    check("t5_fwft_gone", 32'({f_rvalid, f_data_out}), 32'h0);

    // Test 6: reset mid-stream discards contents.
    for (int i = 0; i < 4; i++) step(1, DW'(8'h20 + i), 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("t6_reset_cnt", 32'(count), 32'd0);
    step(1, 8'h3C, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check("t6_readback", 32'(data_out), 32'h3C);

    // Randomized traffic with phases biased toward filling and draining.
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 50) % 2 == 0) ? 70 : 30;
      v = DW'($urandom);
      step($urandom_range(0, 99) < wp, v, $urandom_range(0, 99) < (100 - wp),
           $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
